pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: byte-address width; PC and all address ports are word addresses, ADDR_WIDTH-2 bits wide.
REQ-002 Parameter RESET_ADDR, default 30'h0000_0000: word address loaded into PC on reset.
REQ-003 Parameter TRAP_ADDR, default 30'h0000_0040: word address loaded into PC on a trap.
REQ-004 Parameter STEP, default 1: sequential word increment per accepted fetch (1 to 3).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 redirect_valid  input  1  branch/jump redirect request this cycle.
REQ-008 redirect_addr  input  ADDR_WIDTH-2  redirect target; sampled only when redirect_valid=1.
REQ-009 trap_valid  input  1  trap request this cycle; target is TRAP_ADDR.
REQ-010 halt  input  1  request to stop issuing fetches.
REQ-011 resume  input  1  request to leave HALTED.
REQ-012 fetch_ready  input  1  consumer accepts the current PC.
REQ-013 fetch_valid  output  1  PC is a valid fetch address.
REQ-014 PC  output  ADDR_WIDTH-2  current fetch word address.
REQ-015 pending_valid  output  1  a redirect or trap is buffered and awaits application.
REQ-016 halted  output  1  high while in state HALTED.

Function
REQ-017 States: BOOT, RUN, HALTED; fetch_valid SHALL be 1 only in RUN.
REQ-018 BOOT SHALL last exactly one cycle, then go to HALTED if halt=1, else to RUN.
REQ-019 fire = fetch_valid & fetch_ready; PC SHALL change in RUN only on fire and hold while fetch_valid=1 and fetch_ready=0.
REQ-020 On fire, next PC priority: trap_valid or pending trap -> TRAP_ADDR; else redirect_valid -> redirect_addr; else pending redirect -> buffered address; else PC+STEP.
REQ-021 PC+STEP SHALL wrap modulo 2^(ADDR_WIDTH-2) with no flag or stall.
REQ-022 Without fire in RUN, trap_valid SHALL set the pending entry to trap, overriding any buffered redirect.
REQ-023 Without fire in RUN, redirect_valid SHALL overwrite a buffered redirect but SHALL NOT overwrite a pending trap.
REQ-024 The pending entry SHALL clear on the fire that consumes it; pending_valid SHALL drop in the cycle after that fire.
REQ-025 In BOOT or HALTED, trap_valid or redirect_valid SHALL load PC directly on the next edge (trap wins) and leave pending_valid at 0.
REQ-026 In RUN, halt=1 SHALL move to HALTED on the next edge; a fire in the same cycle SHALL still advance PC per REQ-020.
REQ-027 Entering HALTED SHALL apply any pending entry to PC on the same edge and clear it.
REQ-028 In HALTED, resume=1 or trap_valid=1 SHALL move to RUN on the next edge; halt=1 with resume=1 SHALL stay HALTED unless trap_valid=1.
REQ-029 Latency: PC updates are registered; a target presented in cycle N appears on PC in cycle N+1 when it is applied.

Reset
REQ-030 While reset=1: PC=RESET_ADDR, state=BOOT, fetch_valid=0, pending_valid=0, halted=0, asynchronously and regardless of clk.
REQ-031 Reset asserted mid-operation SHALL discard any pending entry and any in-flight fetch with no residual effect after release.
REQ-032 First fetch after reset release SHALL present RESET_ADDR with fetch_valid=1 in the second cycle after release.

Verification
REQ-033 Release reset, hold fetch_ready=1 for 4 cycles, STEP=1 -> PC sequence 0,1,2,3 with fetch_valid=1 from the second cycle.
REQ-034 fetch_ready=0 at PC=5, redirect_valid=1 with addr 0x100 for one cycle, then fetch_ready=1 -> PC holds 5, pending_valid=1, after fire PC=0x100, pending_valid=0.
REQ-035 Stalled at PC=8: redirect 0x200, then trap_valid, then redirect 0x300, then fire -> PC=TRAP_ADDR (0x40).
REQ-036 Same-cycle fire with trap_valid=1 and redirect_valid=1 (0x80) -> next PC=0x40.
REQ-037 PC=30'h3FFF_FFFF, fire with STEP=1 -> PC=0; halt then resume -> fetch_valid 0 for exactly the halted cycles, PC unchanged.
REQ-038 Assert reset asynchronously between edges while pending_valid=1 -> PC=RESET_ADDR and pending_valid=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit -- program-counter / fetch-address generator.
//
// Holds the current fetch word address and decides where it goes next:
// sequential step, branch redirect, or trap vector. Requests that arrive
// while the consumer stalls are held in a single pending entry. A trap
// always replaces a buffered redirect. A redirect never replaces a
// buffered trap.
//
// Ports
//   clk            : clock, rising edge
//   reset          : asynchronous active-high reset
//   redirect_valid : redirect request, target on redirect_addr
//   redirect_addr  : redirect target word address
//   trap_valid     : trap request, target TRAP_ADDR
//   halt           : stop issuing fetches
//   resume         : leave HALTED
//   fetch_ready    : consumer accepts PC this cycle
//   fetch_valid    : PC is a valid fetch address (RUN only)
//   PC             : current fetch word address
//   pending_valid  : a redirect/trap is buffered
//   halted         : state is HALTED
module pc_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-3:0] RESET_ADDR = 30'h0000_0000,
    parameter logic [ADDR_WIDTH-3:0] TRAP_ADDR  = 30'h0000_0040,
    parameter int                    STEP       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-3:0] redirect_addr,
    input  logic                  trap_valid,
    input  logic                  halt,
    input  logic                  resume,
    input  logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [ADDR_WIDTH-3:0] PC,
    output logic                  pending_valid,
    output logic                  halted
);
    localparam int AW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t        state, state_n;
    logic [AW-1:0] pc, pc_n;
    logic          pend_valid, pend_valid_n;
    logic          pend_trap, pend_trap_n;
    logic [AW-1:0] pend_addr, pend_addr_n;
    logic          fire;

    assign fire          = (state == RUN) && fetch_ready;
    assign fetch_valid   = (state == RUN);
    assign halted        = (state == HALTED);
    assign pending_valid = pend_valid;
    assign PC            = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            pc         <= RESET_ADDR;
            pend_valid <= 1'b0;
            pend_trap  <= 1'b0;
            pend_addr  <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pend_valid <= pend_valid_n;
            pend_trap  <= pend_trap_n;
            pend_addr  <= pend_addr_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pend_valid_n = pend_valid;
        pend_trap_n  = pend_trap;
        pend_addr_n  = pend_addr;
        case (state)
            BOOT, HALTED: begin
                // Not fetching: targets go straight to PC, nothing buffered.
                if (trap_valid)
                    pc_n = TRAP_ADDR;
                else if (redirect_valid)
                    pc_n = redirect_addr;
                pend_valid_n = 1'b0;
                pend_trap_n  = 1'b0;
                if (state == BOOT)
                    state_n = halt ? HALTED : RUN;
                else if (trap_valid || (resume && !halt))
                    state_n = RUN;
            end
            RUN: begin
                if (fire) begin
                    if (trap_valid || (pend_valid && pend_trap))
                        pc_n = TRAP_ADDR;
                    else if (redirect_valid)
                        pc_n = redirect_addr;
                    else if (pend_valid)
                        pc_n = pend_addr;
                    else
                        pc_n = pc + AW'(STEP);  // wraps naturally
                    pend_valid_n = 1'b0;
                    pend_trap_n  = 1'b0;
                end else begin
                    if (trap_valid) begin
                        pend_valid_n = 1'b1;
                        pend_trap_n  = 1'b1;
                    end else if (redirect_valid && !(pend_valid && pend_trap)) begin
                        pend_valid_n = 1'b1;
                        pend_trap_n  = 1'b0;
                        pend_addr_n  = redirect_addr;
                    end
                    // Halting flushes the pending entry (including one
                    // arriving this cycle) into PC so it is not lost.
                    if (halt && pend_valid_n) begin
                        pc_n         = pend_trap_n ? TRAP_ADDR : pend_addr_n;
                        pend_valid_n = 1'b0;
                        pend_trap_n  = 1'b0;
                    end
                end
                if (halt)
                    state_n = HALTED;
            end
            default: state_n = BOOT;
        endcase
    end
endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [29:0] redirect_addr;
    logic        trap_valid;
    logic        halt;
    logic        resume;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [29:0] PC;
    logic        pending_valid;
    logic        halted;

    int checks = 0;
    int failures = 0;

    pc_unit dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .trap_valid(trap_valid), .halt(halt), .resume(resume),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .PC(PC),
        .pending_valid(pending_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [29:0] pc_e, input logic fv_e,
                          input logic pv_e, input logic h_e);
        chk({tag, ".pc"}, {2'b0, PC}, {2'b0, pc_e});
        chk({tag, ".fv"}, {31'b0, fetch_valid}, {31'b0, fv_e});
        chk({tag, ".pv"}, {31'b0, pending_valid}, {31'b0, pv_e});
        chk({tag, ".halted"}, {31'b0, halted}, {31'b0, h_e});
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 0; redirect_addr = '0; trap_valid = 0;
        halt = 0; resume = 0; fetch_ready = 0;
        #3;
        chk_st("reset_pre_clk", 30'h0, 0, 0, 0);
        step(); step();
        reset = 1'b0; fetch_ready = 1;
        chk_st("boot", 30'h0, 0, 0, 0);

        // Sequential fetch 0,1,2,3
        step(); chk_st("seq0", 30'h0, 1, 0, 0);
        step(); chk_st("seq1", 30'h1, 1, 0, 0);
        step(); chk_st("seq2", 30'h2, 1, 0, 0);
        step(); chk_st("seq3", 30'h3, 1, 0, 0);
        step(); step(); chk_st("seq5", 30'h5, 1, 0, 0);

        // Stalled redirect is buffered, applied on fire
        fetch_ready = 0; redirect_valid = 1; redirect_addr = 30'h100;
        step(); chk_st("stall_redir", 30'h5, 1, 1, 0);
        redirect_valid = 0;
        step(); chk_st("stall_hold", 30'h5, 1, 1, 0);
        fetch_ready = 1;
        step(); chk_st("redir_fire", 30'h100, 1, 0, 0);

        // Direct redirect on fire to reach PC=8
        redirect_valid = 1; redirect_addr = 30'h8;
        step(); chk_st("redir_direct", 30'h8, 1, 0, 0);

        // redirect, trap, redirect while stalled: trap survives
        fetch_ready = 0; redirect_addr = 30'h200;
        step(); chk_st("p_redir1", 30'h8, 1, 1, 0);
        redirect_valid = 0; trap_valid = 1;
        step(); chk_st("p_trap", 30'h8, 1, 1, 0);
        trap_valid = 0; redirect_valid = 1; redirect_addr = 30'h300;
        step(); chk_st("p_redir2", 30'h8, 1, 1, 0);
        redirect_valid = 0; fetch_ready = 1;
        step(); chk_st("trap_fire", 30'h40, 1, 0, 0);
        step(); chk_st("post_trap_step", 30'h41, 1, 0, 0);

        // Same-cycle trap and redirect: trap wins
        trap_valid = 1; redirect_valid = 1; redirect_addr = 30'h80;
        step(); chk_st("trap_vs_redir", 30'h40, 1, 0, 0);
        trap_valid = 0; redirect_addr = 30'h3FFF_FFFF;
        step(); chk_st("to_max", 30'h3FFF_FFFF, 1, 0, 0);
        redirect_valid = 0;
        step(); chk_st("wrap", 30'h0, 1, 0, 0);

        // Halt then resume, PC unchanged
        fetch_ready = 0; halt = 1;
        step(); chk_st("halt1", 30'h0, 0, 0, 1);
        halt = 0;
        step(); chk_st("halt2", 30'h0, 0, 0, 1);
        resume = 1;
        step(); chk_st("resume", 30'h0, 1, 0, 0);
        resume = 0;

        // Entering HALTED applies the pending entry
        redirect_valid = 1; redirect_addr = 30'h123;
        step(); chk_st("pend_before_halt", 30'h0, 1, 1, 0);
        redirect_valid = 0; halt = 1;
        step(); chk_st("halt_apply", 30'h123, 0, 0, 1);

        // halt+resume stays halted; trap in HALTED resumes at TRAP_ADDR
        resume = 1;
        step(); chk_st("halt_resume_stay", 30'h123, 0, 0, 1);
        trap_valid = 1;
        step(); chk_st("halted_trap", 30'h40, 1, 0, 0);
        trap_valid = 0; halt = 0; resume = 0;

        // Asynchronous reset with pending entry
        redirect_valid = 1; redirect_addr = 30'h55;
        step(); chk_st("pend_pre_reset", 30'h40, 1, 1, 0);
        redirect_valid = 0;
        #2 reset = 1;
        #1 chk_st("async_reset", 30'h0, 0, 0, 0);
        step();
        reset = 0; fetch_ready = 1;
        chk_st("boot2", 30'h0, 0, 0, 0);
        step(); chk_st("first_fetch2", 30'h0, 1, 0, 0);
        step(); chk_st("second_fetch2", 30'h1, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
